// File: rtl/mpeg_sc_pkg.sv
// MPEG start-code constants, output record type and small decode helpers.
// Latency: none (definitions only).
// Backpressure: not applicable.
package mpeg_sc_pkg;

   localparam logic [23:0] SC_PREFIX  = 24'h000001;
   localparam logic [7:0]  SC_PICTURE = 8'h00;
   localparam logic [7:0]  SC_SEQ_HDR = 8'hB3;
   localparam logic [7:0]  SC_PACK    = 8'hBA;
   localparam logic [7:0]  SC_VID_LO  = 8'hE0;
   localparam logic [7:0]  SC_VID_HI  = 8'hEF;
   localparam logic [7:0]  SC_SEQ_END = 8'hB7;

   // One registered output beat.
   typedef struct packed {
      logic       vld;
      logic [7:0] dat;
      logic       first;
      logic [7:0] code;
      logic       last;
   } sc_out_t;

   function automatic logic is_prefix(input logic [7:0] b0, input logic [7:0] b1,
                                      input logic [7:0] b2);
      return {b0, b1, b2} == SC_PREFIX;
   endfunction

   function automatic logic is_vid_code(input logic [7:0] c);
      return (c >= SC_VID_LO) && (c <= SC_VID_HI);
   endfunction

endpackage

// File: rtl/mpeg_sc_fifo.sv
// Synchronous byte FIFO with occupancy count, registered prog_full and sticky overflow.
// Latency: a written byte is readable the cycle after the write.
// Backpressure: no write ready; writes while full are dropped and latch overflow.
module mpeg_sc_fifo #(
   parameter int DEPTH     = 16,
   parameter int PROG_FULL = 12
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clk_en,
   input  logic       wr_vld,
   input  logic [7:0] wr_dat,
   input  logic       rd_rdy,
   output logic       rd_vld,
   output logic [7:0] rd_dat,
   output logic       prog_full,
   output logic       overflow
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
   localparam logic [AW:0]   PF_C    = (AW+1)'(PROG_FULL);
   localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          prog_full_q, prog_full_d, overflow_q, overflow_d;
   logic          full, empty, push, pop;

   // Push/pop decisions; a write while full is a drop even if a read frees a slot
   always_comb begin
      full        = (count_q == DEPTH_C);
      empty       = (count_q == '0);
      push        = clk_en & wr_vld & ~full;
      pop         = clk_en & rd_rdy & ~empty;
      wr_ptr_d    = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d    = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      count_d     = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
      prog_full_d = (count_d >= PF_C);
      overflow_d  = overflow_q | (clk_en & wr_vld & full);
   end

   // Control state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         prog_full_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else if (clk_en) begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         prog_full_q <= prog_full_d;
         overflow_q  <= overflow_d;
      end
   end

   // Storage array, no reset needed: contents are qualified by count
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wr_dat;
   end

   assign rd_vld    = ~empty;
   assign rd_dat    = mem_q[rd_ptr_q];
   assign prog_full = prog_full_q;
   assign overflow  = overflow_q;

endmodule

// File: rtl/mpeg_sc_scanner.sv
// Start-code scanner: buffers the byte stream, tags the first 0x00 of each 00 00 01 xx prefix.
// Latency: 6 cycles input to sc_valid (FIFO, 4-slot window, output register); flushed tail sooner.
// Backpressure: valid/ready on output; mpeg_prog_full throttles the source. SC_STATS_EN adds counters.
module mpeg_sc_scanner #(
   parameter int FIFO_DEPTH = 16,
   parameter int PROG_FULL  = 12
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clk_en,
   input  logic [7:0]  mpeg_in,
   input  logic        mpeg_in_en,
   input  logic        stream_end,
   output logic        mpeg_prog_full,
   output logic [7:0]  sc_byte,
   output logic        sc_valid,
   input  logic        sc_ready,
   output logic        sc_first,
   output logic [7:0]  sc_code,
   output logic        sc_last,
   output logic        overflow,
   output logic [31:0] sc_cnt,
   output logic [31:0] vid_sc_cnt
);
   import mpeg_sc_pkg::*;

   logic            fifo_vld, fifo_pop;
   logic [7:0]      fifo_dat;
   logic [3:0][7:0] win_q, win_d;
   logic [3:0]      wv_q, wv_d;
   sc_out_t         out_q, out_d;
   logic            done_q, done_d;
   logic            accept, out_free, win_full, win_contig, flush, load, tag, is_last;
   logic            take0, take1, take2;

   mpeg_sc_fifo #(.DEPTH(FIFO_DEPTH), .PROG_FULL(PROG_FULL)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .clk_en    (clk_en),
      .wr_vld    (mpeg_in_en),
      .wr_dat    (mpeg_in),
      .rd_rdy    (fifo_pop),
      .rd_vld    (fifo_vld),
      .rd_dat    (fifo_dat),
      .prog_full (mpeg_prog_full),
      .overflow  (overflow)
   );

   // Window compaction toward w0 and output-register load; flush waits for a gap-free window
   always_comb begin
      accept     = out_q.vld & sc_ready;
      out_free   = ~out_q.vld | sc_ready;
      win_full   = &wv_q;
      win_contig = (wv_q == 4'b0001) | (wv_q == 4'b0011) | (wv_q == 4'b0111) | win_full;
      flush      = stream_end & ~fifo_vld;
      load       = ~done_q & out_free & wv_q[0] & (win_full | (flush & win_contig));
      is_last    = flush & (wv_q == 4'b0001);
      take0      = wv_q[1] & (~wv_q[0] | load);
      take1      = wv_q[2] & (~wv_q[1] | take0);
      take2      = wv_q[3] & (~wv_q[2] | take1);
      fifo_pop   = fifo_vld & (~wv_q[3] | take2);
      tag        = win_full & is_prefix(win_q[0], win_q[1], win_q[2]);

      win_d = win_q;
      wv_d  = wv_q;
      if (take0) begin
         win_d[0] = win_q[1];
         wv_d[0]  = 1'b1;
      end else if (load) begin
         wv_d[0]  = 1'b0;
      end
      if (take1) begin
         win_d[1] = win_q[2];
         wv_d[1]  = 1'b1;
      end else if (take0) begin
         wv_d[1]  = 1'b0;
      end
      if (take2) begin
         win_d[2] = win_q[3];
         wv_d[2]  = 1'b1;
      end else if (take1) begin
         wv_d[2]  = 1'b0;
      end
      if (fifo_pop) begin
         win_d[3] = fifo_dat;
         wv_d[3]  = 1'b1;
      end else if (take2) begin
         wv_d[3]  = 1'b0;
      end

      out_d  = out_q;
      done_d = done_q;
      if (load) begin
         out_d.vld   = 1'b1;
         out_d.dat   = win_q[0];
         out_d.first = tag;
         out_d.code  = tag ? win_q[3] : 8'h00;
         out_d.last  = is_last;
         done_d      = is_last;
      end else if (accept) begin
         out_d = '0;
      end
   end

   // Window, output register and end-of-stream latch, all frozen while clk_en is low
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_q  <= '0;
         wv_q   <= '0;
         out_q  <= '0;
         done_q <= 1'b0;
      end else if (clk_en) begin
         win_q  <= win_d;
         wv_q   <= wv_d;
         out_q  <= out_d;
         done_q <= done_d;
      end
   end

   assign sc_valid = out_q.vld;
   assign sc_byte  = out_q.dat;
   assign sc_first = out_q.first;
   assign sc_code  = out_q.code;
   assign sc_last  = out_q.last;

`ifdef SC_STATS_EN
   logic [31:0] sc_cnt_q, sc_cnt_d, vid_cnt_q, vid_cnt_d;

   // Count accepted tagged bytes; video codes also counted separately
   always_comb begin
      sc_cnt_d  = sc_cnt_q;
      vid_cnt_d = vid_cnt_q;
      if (accept & out_q.first) begin
         sc_cnt_d = sc_cnt_q + 32'd1;
         if (is_vid_code(out_q.code)) vid_cnt_d = vid_cnt_q + 32'd1;
      end
   end

   // Statistics registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sc_cnt_q  <= '0;
         vid_cnt_q <= '0;
      end else if (clk_en) begin
         sc_cnt_q  <= sc_cnt_d;
         vid_cnt_q <= vid_cnt_d;
      end
   end

   assign sc_cnt     = sc_cnt_q;
   assign vid_sc_cnt = vid_cnt_q;
`else
   assign sc_cnt     = '0;
   assign vid_sc_cnt = '0;
`endif

endmodule

// File: tb/tb_mpeg_sc_scanner.sv
// Bench for mpeg_sc_scanner: directed and random byte streams against a stream-level reference.
// Latency: not applicable.
// Backpressure: drives sc_ready/clk_en patterns and obeys mpeg_prog_full except in the drop test.
module tb_mpeg_sc_scanner;
   import mpeg_sc_pkg::*;

   logic        clk;
   logic        rst_n, clk_en, mpeg_in_en, stream_end, sc_ready;
   logic [7:0]  mpeg_in;
   logic        mpeg_prog_full, sc_valid, sc_first, sc_last, overflow;
   logic [7:0]  sc_byte, sc_code;
   logic [31:0] sc_cnt, vid_sc_cnt;

   int n_chk = 0, n_pass = 0, n_fail = 0;
   int cyc = 0;
   int fv_cyc = -1;
   logic [7:0]  src_q[$];
   logic [17:0] got_q[$];

   mpeg_sc_scanner dut (
      .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .mpeg_in(mpeg_in), .mpeg_in_en(mpeg_in_en),
      .stream_end(stream_end), .mpeg_prog_full(mpeg_prog_full), .sc_byte(sc_byte),
      .sc_valid(sc_valid), .sc_ready(sc_ready), .sc_first(sc_first), .sc_code(sc_code),
      .sc_last(sc_last), .overflow(overflow), .sc_cnt(sc_cnt), .vid_sc_cnt(vid_sc_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Record every accepted beat as {last, first, code, byte}
   always @(negedge clk) begin
      if (rst_n === 1'b1 && clk_en && sc_valid && sc_ready)
         got_q.push_back({sc_last, sc_first, sc_code, sc_byte});
      if (rst_n === 1'b1 && sc_valid && fv_cyc < 0) fv_cyc = cyc;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got %0d beats of %0d", got_q.size(), src_q.size());
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: a byte is tagged iff it starts 00 00 01 and a code byte follows it in the stream
   function automatic logic [17:0] exp_rec(input int i);
      int   n;
      logic f;
      logic [7:0] code;
      n    = src_q.size();
      f    = 1'b0;
      code = 8'h00;
      if (i + 3 < n) begin
         if (src_q[i] == 8'h00 && src_q[i+1] == 8'h00 && src_q[i+2] == 8'h01) begin
            f    = 1'b1;
            code = src_q[i+3];
         end
      end
      return {(i == n - 1), f, code, src_q[i]};
   endfunction

   function automatic logic [7:0] rnd_byte();
      case ($urandom_range(7))
         0, 1, 2, 3: return 8'h00;
         4:          return 8'h01;
         5:          return SC_VID_LO + 8'($urandom_range(15));
         6:          return SC_SEQ_HDR;
         default:    return 8'($urandom);
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] b, input bit keep);
      mpeg_in    = b;
      mpeg_in_en = 1'b1;
      if (keep) src_q.push_back(b);
      step();
      mpeg_in_en = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; clk_en = 1'b1; mpeg_in_en = 1'b0; mpeg_in = 8'h00;
      stream_end = 1'b0; sc_ready = 1'b0;
      step(); step();
      got_q.delete(); src_q.delete(); fv_cyc = -1;
      rst_n = 1'b1;
      step();
   endtask

   task automatic drain(input bit rnd);
      int k;
      stream_end = 1'b1;
      k = 0;
      while (got_q.size() < src_q.size() && k < 3000) begin
         if (rnd) begin
            sc_ready = ($urandom_range(3) != 0);
            clk_en   = ($urandom_range(9) != 0);
         end else begin
            sc_ready = 1'b1;
            clk_en   = 1'b1;
         end
         step();
         k++;
      end
      sc_ready = 1'b1;
      clk_en   = 1'b1;
      repeat (6) step();
   endtask

   task automatic compare_stream(input string tag);
      int n;
      n = src_q.size();
      chk($sformatf("%s_count", tag), got_q.size(), n);
      chk($sformatf("%s_valid_after_last", tag), sc_valid, 1'b0);
      for (int i = 0; i < n; i++)
         chk($sformatf("%s_beat%0d", tag, i), (i < got_q.size()) ? got_q[i] : 18'h3ffff, exp_rec(i));
   endtask

   task automatic check_stats(input string tag);
      int e_sc, e_vid;
      logic [17:0] r;
      e_sc = 0; e_vid = 0;
      for (int i = 0; i < src_q.size(); i++) begin
         r = exp_rec(i);
         if (r[16]) begin
            e_sc++;
            if (r[15:8] >= 8'hE0 && r[15:8] <= 8'hEF) e_vid++;
         end
      end
`ifdef SC_STATS_EN
      chk($sformatf("%s_sc_cnt", tag), sc_cnt, e_sc);
      chk($sformatf("%s_vid_cnt", tag), vid_sc_cnt, e_vid);
`else
      chk($sformatf("%s_sc_cnt", tag), sc_cnt, 32'd0);
      chk($sformatf("%s_vid_cnt", tag), vid_sc_cnt, 32'd0);
`endif
   endtask

   initial begin
      logic [7:0] b;
      int t0, pushed, it;
      bit saw_pf;

      // Reset state
      do_reset();
      chk("rst_valid", sc_valid, 1'b0);
      chk("rst_byte", sc_byte, 8'h00);
      chk("rst_first_code_last", {sc_first, sc_code, sc_last}, 10'h000);
      chk("rst_overflow", overflow, 1'b0);
      chk("rst_prog_full", mpeg_prog_full, 1'b0);
      chk("rst_sc_cnt", sc_cnt, 32'd0);
      chk("rst_vid_cnt", vid_sc_cnt, 32'd0);

      // Pack start code followed by one data byte, with first-byte latency
      sc_ready = 1'b1;
      t0 = cyc;
      push(8'h00, 1); push(8'h00, 1); push(8'h01, 1); push(SC_PACK, 1); push(8'h44, 1);
      drain(0);
      chk("latency_first_valid", fv_cyc, t0 + 6);
      compare_stream("pack");
      check_stats("pack");

      // Overlapping zeros before a video start code
      do_reset();
      sc_ready = 1'b1;
      push(8'h00, 1); push(8'h00, 1); push(8'h00, 1); push(8'h01, 1); push(8'hE0, 1);
      drain(0);
      compare_stream("overlap");
      check_stats("overlap");

      // Stalled output, source obeys prog_full
      do_reset();
      pushed = 0;
      saw_pf = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (mpeg_prog_full) begin
            saw_pf = 1'b1;
            step();
         end else begin
            push(8'($urandom), 1);
            pushed++;
         end
      end
      chk("pf_seen", saw_pf, 1'b1);
      chk("pf_pushed", pushed, 17);
      chk("pf_no_overflow", overflow, 1'b0);
      chk("pf_stall_valid", sc_valid, 1'b1);
      chk("pf_stall_byte", sc_byte, src_q[0]);
      drain(0);
      compare_stream("pf");
      chk("pf_released", mpeg_prog_full, 1'b0);

      // Source ignores prog_full: 25 bytes, only 21 fit
      do_reset();
      for (int i = 0; i < 25; i++) push(8'($urandom), i < 21);
      chk("ovf_set", overflow, 1'b1);
      chk("ovf_prog_full", mpeg_prog_full, 1'b1);
      drain(0);
      compare_stream("ovf");
      chk("ovf_sticky", overflow, 1'b1);

      // Stream ends with a truncated prefix
      do_reset();
      sc_ready = 1'b1;
      push(8'h55, 1); push(8'h00, 1); push(8'h00, 1); push(8'h01, 1);
      drain(0);
      compare_stream("trunc");

      // Reset in the middle of a prefix, then a fresh sequence header
      do_reset();
      push(8'h11, 1); push(8'h22, 1); push(8'h33, 1); push(8'h44, 1);
      push(8'h00, 1); push(8'h00, 1);
      step(); step();
      chk("mid_pre_valid", sc_valid, 1'b1);
      chk("mid_pre_byte", sc_byte, 8'h11);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", sc_valid, 1'b0);
      chk("mid_rst_byte", sc_byte, 8'h00);
      step();
      got_q.delete(); src_q.delete(); fv_cyc = -1;
      rst_n = 1'b1;
      step();
      sc_ready = 1'b1;
      push(8'h00, 1); push(8'h00, 1); push(8'h01, 1); push(SC_SEQ_HDR, 1);
      drain(0);
      compare_stream("post_rst");

      // Random stream with random ready, clk_en and idle cycles; junk offered while clk_en is low
      do_reset();
      pushed = 0;
      it = 0;
      while (pushed < 300 && it < 5000) begin
         clk_en   = ($urandom_range(9) != 0);
         sc_ready = ($urandom_range(3) != 0);
         if (!mpeg_prog_full && $urandom_range(3) != 0) begin
            b          = rnd_byte();
            mpeg_in    = b;
            mpeg_in_en = 1'b1;
            if (clk_en) begin
               src_q.push_back(b);
               pushed++;
            end
         end else begin
            mpeg_in_en = 1'b0;
         end
         step();
         it++;
      end
      mpeg_in_en = 1'b0;
      drain(1);
      compare_stream("rand");
      check_stats("rand");
      chk("rand_no_overflow", overflow, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
